// File: rtl/regex_instr_memory.sv
// Regex CPU instruction memory: fetch port grants LATENCY cycles after the request is seen,
// and a program-load write port is accepted only while idle with no fetch requested.
module regex_instr_memory #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int LATENCY           = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         memory_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic                         memory_ready,
  output logic [MEMORY_WIDTH-1:0]      memory_data,
  input  logic                         load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEMORY_WIDTH-1:0]      load_data,
  output logic                         load_ready,
  output logic                         protocol_error,
  output logic [15:0]                  fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [2:0] WAIT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  logic [MEMORY_WIDTH-1:0]      mem [2**MEMORY_ADDR_WIDTH];
  logic [1:0]                   state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEMORY_WIDTH-1:0]      data_q, data_d;
  logic                         perr_q, perr_d;
  logic [15:0]                  fcnt_q, fcnt_d;
  logic                         load_en;

  // Gated with rst so no load is reported or written while reset is held.
  assign load_en = rst && (state_q == IDLE) && !memory_valid && load_valid;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (memory_valid) begin
          addr_d = memory_addr;
          if (LATENCY == 1) begin
            state_d = GRANT;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      GRANT: begin
        // A requester that let go before the grant gets nothing and is flagged.
        if (memory_valid) begin
          data_d = mem[addr_q];
          fcnt_d = fcnt_q + 16'd1;
        end else begin
          perr_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign memory_ready   = (state_q == GRANT);
  assign memory_data    = data_q;
  assign load_ready     = load_en;
  assign protocol_error = perr_q;
  assign fetch_count    = fcnt_q;

endmodule

// File: tb/tb_regex_instr_memory.sv
// Bench for regex_instr_memory: three instances (LATENCY 1, 2, 4) checked every cycle against
// a cycle-count model, plus directed scenarios with literal expectations.
module tb_regex_instr_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mv, rdy, lrdy, perr;
  logic [10:0] ma, la;
  logic        lv;
  logic [15:0] ld;
  logic [15:0] dat  [3];
  logic [15:0] fcnt [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    regex_instr_memory #(
      .MEMORY_WIDTH(16),
      .MEMORY_ADDR_WIDTH(11),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .memory_valid   (mv[g]),
      .memory_addr    (ma),
      .memory_ready   (rdy[g]),
      .memory_data    (dat[g]),
      .load_valid     (lv),
      .load_addr      (la),
      .load_data      (ld),
      .load_ready     (lrdy[g]),
      .protocol_error (perr[g]),
      .fetch_count    (fcnt[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a request seen in idle at cycle c is granted in cycle c+LATENCY;
  // the grant edge transfers if valid is still high, otherwise flags an error.
  logic [15:0] m_mem  [3][2048];
  bit          m_busy [3];
  int          m_sight[3];
  logic [10:0] m_addr [3];
  logic [15:0] m_data [3];
  logic [15:0] m_cnt  [3];
  bit          m_perr [3];
  int          cyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit grant_now;
      bit exp_lrdy;
      if (!rst) begin
        m_busy[i] = 1'b0;
        m_data[i] = 16'd0;
        m_cnt[i]  = 16'd0;
        m_perr[i] = 1'b0;
      end
      grant_now = m_busy[i] && (cyc == m_sight[i] + lat_of(i));
      exp_lrdy  = rst && !m_busy[i] && !mv[i] && lv;
      check("memory_ready",   i, 32'(rdy[i]),  32'(grant_now));
      check("load_ready",     i, 32'(lrdy[i]), 32'(exp_lrdy));
      check("memory_data",    i, 32'(dat[i]),  32'(m_data[i]));
      check("fetch_count",    i, 32'(fcnt[i]), 32'(m_cnt[i]));
      check("protocol_error", i, 32'(perr[i]), 32'(m_perr[i]));
      if (rst) begin
        if (m_busy[i]) begin
          if (grant_now) begin
            if (mv[i]) begin
              m_data[i] = m_mem[i][m_addr[i]];
              m_cnt[i]  = m_cnt[i] + 16'd1;
            end else begin
              m_perr[i] = 1'b1;
            end
            m_busy[i] = 1'b0;
          end
        end else if (mv[i]) begin
          m_busy[i]  = 1'b1;
          m_sight[i] = cyc;
          m_addr[i]  = ma;
        end else if (lv) begin
          m_mem[i][la] = ld;
        end
      end
    end
    cyc++;
  end

  task automatic load(input logic [10:0] a, input logic [15:0] d);
    lv = 1'b1;
    la = a;
    ld = d;
    #1;
    check("lit_load_ready", 0, 32'(lrdy[0]), 32'd1);
    tick();
    lv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mv  = 3'b000;
    ma  = '0;
    lv  = 1'b0;
    la  = '0;
    ld  = '0;
    #1 rst = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check("lit_reset_ready", i, 32'(rdy[i]),  32'd0);
      check("lit_reset_data",  i, 32'(dat[i]),  32'd0);
      check("lit_reset_count", i, 32'(fcnt[i]), 32'd0);
      check("lit_reset_perr",  i, 32'(perr[i]), 32'd0);
    end
    rst = 1'b1;
    tick();

    load(11'h0F5, 16'h1234);
    load(11'h040, 16'hBEEF);
    load(11'h041, 16'h0BAD);
    load(11'h010, 16'h5555);
    load(11'h100, 16'hC0DE);
    tick();

    // LATENCY=1 fetch of a freshly loaded word
    mv[0] = 1'b1;
    ma    = 11'h0F5;
    tick();
    check("lit_l1_ready", 0, 32'(rdy[0]), 32'd1);
    tick();
    mv[0] = 1'b0;
    check("lit_l1_data",  0, 32'(dat[0]),  32'h1234);
    check("lit_l1_count", 0, 32'(fcnt[0]), 32'd1);
    check("lit_l1_ready_after", 0, 32'(rdy[0]), 32'd0);
    tick(2);

    // LATENCY=4 with the address changing mid-wait
    mv[2] = 1'b1;
    ma    = 11'h040;
    tick(2);
    ma = 11'h041;
    tick();
    check("lit_l4_ready_c3", 2, 32'(rdy[2]), 32'd0);
    tick();
    check("lit_l4_ready_c4", 2, 32'(rdy[2]), 32'd1);
    tick();
    mv[2] = 1'b0;
    check("lit_l4_data", 2, 32'(dat[2]), 32'hBEEF);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("lit_l4_no_pulse", 2, 32'(rdy[2]), 32'd0);
    end

    // fetch and load collide: fetch first, load afterwards
    mv[0] = 1'b1;
    ma    = 11'h010;
    lv    = 1'b1;
    la    = 11'h010;
    ld    = 16'hAAAA;
    #1;
    check("lit_collide_lrdy_blocked", 0, 32'(lrdy[0]), 32'd0);
    tick(2);
    mv[0] = 1'b0;
    #1;
    check("lit_collide_old_data", 0, 32'(dat[0]),  32'h5555);
    check("lit_collide_lrdy",     0, 32'(lrdy[0]), 32'd1);
    tick();
    lv    = 1'b0;
    mv[0] = 1'b1;
    ma    = 11'h010;
    tick(2);
    mv[0] = 1'b0;
    check("lit_refetch_data",  0, 32'(dat[0]),  32'hAAAA);
    check("lit_refetch_count", 0, 32'(fcnt[0]), 32'd3);
    tick(2);

    // LATENCY=2: one good fetch, then valid dropped in WAIT
    mv[1] = 1'b1;
    ma    = 11'h100;
    tick(2);
    check("lit_l2_ready", 1, 32'(rdy[1]), 32'd1);
    tick();
    mv[1] = 1'b0;
    check("lit_l2_data", 1, 32'(dat[1]), 32'hC0DE);
    tick(2);
    mv[1] = 1'b1;
    ma    = 11'h100;
    tick();
    mv[1] = 1'b0;
    tick();
    check("lit_drop_ready", 1, 32'(rdy[1]), 32'd1);
    tick();
    check("lit_drop_perr",  1, 32'(perr[1]), 32'd1);
    check("lit_drop_data",  1, 32'(dat[1]),  32'hC0DE);
    check("lit_drop_count", 1, 32'(fcnt[1]), 32'd1);
    tick(5);
    check("lit_perr_sticky", 1, 32'(perr[1]), 32'd1);

    // reset in the middle of a LATENCY=4 wait
    mv[2] = 1'b1;
    ma    = 11'h0F5;
    tick(2);
    rst   = 1'b0;
    mv[2] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("lit_rst_ready", i, 32'(rdy[i]),  32'd0);
      check("lit_rst_data",  i, 32'(dat[i]),  32'd0);
      check("lit_rst_count", i, 32'(fcnt[i]), 32'd0);
      check("lit_rst_perr",  i, 32'(perr[i]), 32'd0);
      check("lit_rst_lrdy",  i, 32'(lrdy[i]), 32'd0);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("lit_rst_no_grant", 2, 32'(rdy[2]), 32'd0);
    end
    mv[2] = 1'b1;
    ma    = 11'h0F5;
    tick(4);
    check("lit_post_rst_ready", 2, 32'(rdy[2]), 32'd1);
    tick();
    mv[2] = 1'b0;
    check("lit_post_rst_data",  2, 32'(dat[2]),  32'h1234);
    check("lit_post_rst_count", 2, 32'(fcnt[2]), 32'd1);
    tick(2);

    // 65537 back-to-back fetches wrap the count to 1
    mv[0] = 1'b1;
    ma    = 11'h0F5;
    tick(2 * 65537);
    mv[0] = 1'b0;
    check("lit_wrap_count", 0, 32'(fcnt[0]), 32'd1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regex_instr_memory.md
REGEX_INSTR_MEMORY -- requirements
Module: regex_instr_memory

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter MEMORY_ADDR_WIDTH, default 11, address width; depth = 2**MEMORY_ADDR_WIDTH words.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..8, cycles from request sighting to memory_ready.
REQ-004 SHALL have ports, one clock, asynchronous active-low reset:
  clk              in   1                  sole clock, rising edge
  rst              in   1                  asynchronous, active-low reset
  memory_valid     in   1                  CPU fetch request
  memory_addr      in   MEMORY_ADDR_WIDTH  fetch address
  memory_ready     out  1                  one-cycle grant pulse
  memory_data      out  MEMORY_WIDTH       fetched instruction word
  load_valid       in   1                  program-load write request
  load_addr        in   MEMORY_ADDR_WIDTH  write address
  load_data        in   MEMORY_WIDTH       write data
  load_ready       out  1                  write accepted this cycle
  protocol_error   out  1                  sticky: CPU dropped memory_valid before grant
  fetch_count      out  16                 completed fetches, wraps

Function
REQ-005 SHALL hold the storage array, MEMORY_WIDTH x 2**MEMORY_ADDR_WIDTH, with synchronous write.
REQ-006 SHALL implement an FSM with states IDLE, WAIT and GRANT.
REQ-007 In IDLE with memory_valid=1: latch memory_addr. If LATENCY=1, go to GRANT. Otherwise go to WAIT with counter = LATENCY-2.
REQ-008 In WAIT: decrement the counter each cycle; go to GRANT on the cycle the counter is 0.
REQ-009 memory_ready SHALL be 1 only in GRANT, exactly one cycle per request.
  - Timing: request first sampled in IDLE at cycle 0, memory_ready high in cycle LATENCY.
REQ-010 Transfer occurs at the GRANT rising edge when memory_valid=1. On transfer:
  - memory_data <= word at the latched address, visible the cycle after the grant;
  - fetch_count += 1, wrapping 0xFFFF -> 0;
  - return to IDLE.
REQ-011 If memory_valid=0 at the GRANT edge: no transfer, memory_data unchanged, fetch_count unchanged, protocol_error <= 1 (sticky), return to IDLE.
REQ-012 memory_data SHALL hold its value between transfers.
REQ-013 memory_addr changes after the IDLE sighting SHALL be ignored; the latched address is used.
REQ-014 load_ready SHALL be high only when state=IDLE and memory_valid=0 and load_valid=1.
  - The write occurs at that edge; load_ready and the write happen in the same cycle.
REQ-015 Simultaneous memory_valid and load_valid in IDLE: the fetch wins and the load waits, load_ready=0.
REQ-016 A fetch accepted after a load to the same address SHALL return the newly written data.
REQ-017 Back-to-back fetches: memory_valid held high in the cycle after a transfer is sighted in IDLE that cycle.
  - Minimum spacing between grants is therefore LATENCY+1 cycles.
REQ-018 memory_valid rising during WAIT or GRANT of another request is not possible by protocol and needs no handling.

Reset
REQ-019 rst=0 SHALL asynchronously force: state=IDLE, counter=0, memory_ready=0, memory_data=0, load_ready=0, protocol_error=0, fetch_count=0.
REQ-020 Reset SHALL NOT clear array contents.
REQ-021 Reset asserted during WAIT or GRANT SHALL abort the request.
  - No grant pulse follows reset release unless memory_valid is sampled anew in IDLE.

Verification
REQ-022 LATENCY=1: load 0x1234 at addr 0x0F5, then hold memory_valid with addr 0x0F5.
  - Required: memory_ready high exactly 1 cycle after sighting;
  - memory_data=0x1234 the next cycle; fetch_count=1.
REQ-023 LATENCY=4: fetch addr 0x040, changing memory_addr to 0x041 in cycle 2.
  - Required: memory_ready in cycle 4 only;
  - memory_data returns the addr-0x040 word; no second pulse while memory_valid=0.
REQ-024 memory_valid and load_valid both high in IDLE (load addr 0x010 data 0xAAAA; fetch addr 0x010, old data 0x5555).
  - Required: fetch returns 0x5555;
  - load_ready pulses the cycle after the fetch returns to IDLE; a refetch then returns 0xAAAA.
REQ-025 LATENCY=2: memory_valid dropped in WAIT.
  - Required: protocol_error=1 after the GRANT edge and stays 1;
  - memory_data and fetch_count unchanged.
REQ-026 Reset asserted mid-WAIT, then released with memory_valid=0.
  - Required: all outputs 0 immediately; no memory_ready in the following 10 cycles;
  - array word written before reset still reads back intact.
REQ-027 65537 fetches: fetch_count SHALL read 0x0001 after wrap.
